// File: rtl/regfile_bypass_if.sv
// Decode/writeback-facing bundle of the bypassed register file: read indices, write port, load scoreboard.
// Combinational read side; write and pending-set take effect on the clock edge.
// No backpressure; the ready flag gates writes and reads during the post-reset sweep.
interface regfile_bypass_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [2:0]            wr_mode;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  pend_set;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic                  rs1_pending;
    logic                  rs2_pending;
    logic                  ready;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output rs1_addr, rs2_addr, wr_mode, wr_addr, wr_data, pend_set, pend_addr,
        input  rd1, rd2, rs1_pending, rs2_pending, ready, a0
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_mode, wr_addr, wr_data, pend_set, pend_addr,
        output rd1, rd2, rs1_pending, rs2_pending, ready, a0
    );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with two bypassed read ports, load-extension writes, pending scoreboard and post-reset clear sweep.
// Reads/pending are zero-latency combinational; writes land at the next edge; sweep takes NREGS cycles.
// No backpressure; while ready is low, writes and pend_set are dropped and all outputs read 0.
module regfile_bypass #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEBUG_REG  = 10
) (
    input  logic            clk,
    input  logic            rst,
    regfile_bypass_if.slave bus
);
    localparam int NREGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] DBG_REG  = ADDR_WIDTH'(DEBUG_REG);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  ready_q;
    logic [NREGS-1:0]      pend_q;
    logic [DATA_WIDTH-1:0] regs [NREGS];

    logic [DATA_WIDTH-1:0] wv;
    logic                  mode_ok;
    logic                  wr_active;
    logic                  set_active;
    logic                  hit1;
    logic                  hit2;
    logic                  hit_dbg;

    // Load-extension shaping of the raw writeback data.
    always_comb begin
        wv      = '0;
        mode_ok = 1'b1;
        case (bus.wr_mode)
            3'b001:  wv = bus.wr_data;
            3'b010:  wv = DATA_WIDTH'($signed(bus.wr_data[15:0]));
            3'b011:  wv = DATA_WIDTH'($signed(bus.wr_data[7:0]));
            3'b110:  wv = DATA_WIDTH'(bus.wr_data[15:0]);
            3'b111:  wv = DATA_WIDTH'(bus.wr_data[7:0]);
            default: mode_ok = 1'b0;
        endcase
    end

    assign wr_active  = ready_q & mode_ok & (bus.wr_addr != '0);
    assign set_active = ready_q & bus.pend_set & (bus.pend_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            ready_q   <= 1'b0;
            pend_q    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                    if (sweep_cnt == LAST_REG) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Later assignment wins: a new load supersedes the same-cycle writeback.
                    if (mode_ok) pend_q[bus.wr_addr] <= 1'b0;
                    if (set_active) pend_q[bus.pend_addr] <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) regs[sweep_cnt] <= '0;
            else if (wr_active) regs[bus.wr_addr] <= wv;
        end
    end

    assign hit1    = wr_active & (bus.wr_addr == bus.rs1_addr);
    assign hit2    = wr_active & (bus.wr_addr == bus.rs2_addr);
    assign hit_dbg = wr_active & (bus.wr_addr == DBG_REG);

    assign bus.rd1 = (!ready_q || bus.rs1_addr == '0) ? '0 :
                     hit1 ? wv : regs[bus.rs1_addr];
    assign bus.rd2 = (!ready_q || bus.rs2_addr == '0) ? '0 :
                     hit2 ? wv : regs[bus.rs2_addr];
    assign bus.a0  = (!ready_q || DBG_REG == '0) ? '0 :
                     hit_dbg ? wv : regs[DBG_REG];

    // A same-cycle write hides the pending bit unless a same-cycle set re-arms it.
    assign bus.rs1_pending = ready_q & pend_q[bus.rs1_addr] &
                             ~(hit1 & ~(set_active & (bus.pend_addr == bus.rs1_addr)));
    assign bus.rs2_pending = ready_q & pend_q[bus.rs2_addr] &
                             ~(hit2 & ~(set_active & (bus.pend_addr == bus.rs2_addr)));

    assign bus.ready = ready_q;
endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor to the single-cycle integer register file, for the pipelined core.
- Two combinational read ports with write-to-read bypass and hardwired-zero register 0.
- Load-extension write modes; per-register pending scoreboard for in-flight loads.
- Sequential clear sweep after reset, gated by a ready flag.
- Sits between decode (reads, pending set) and writeback (writes).

Parameters:
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width; must be >= 16.
- DEBUG_REG, 10, index driven on a0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rs1_addr  in  ADDR_WIDTH  read port 1 index
- rs2_addr  in  ADDR_WIDTH  read port 2 index
- wr_mode  in  3  write mode: 000 none, 001 word, 010 half sign-ext, 011 byte sign-ext, 110 half zero-ext, 111 byte zero-ext; other codes = none
- wr_addr  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  raw writeback data
- pend_set  in  1  mark pend_addr pending (load issued)
- pend_addr  in  ADDR_WIDTH  destination of issued load
- rd1  out  DATA_WIDTH  read data 1
- rd2  out  DATA_WIDTH  read data 2
- rs1_pending  out  1  pending bit of rs1_addr
- rs2_pending  out  1  pending bit of rs2_addr
- ready  out  1  high when the clear sweep is complete
- a0  out  DATA_WIDTH  debug copy of register DEBUG_REG

Behaviour:
- Write value (wv) is formed from wr_data by mode:
  - word: as is.
  - half: bits [15:0], extended with bit 15 (sign) or zeros.
  - byte: bits [7:0], extended with bit 7 (sign) or zeros.
- wr_active = ready & mode valid & wr_addr != 0.
- FSM states: CLEAR, RUN.
- rst (any state, any cycle, including mid-sweep): next state CLEAR, sweep counter 0, all pending bits 0, ready 0.
- CLEAR:
  - Each cycle writes 0 to register[counter], then counter++.
  - After writing register NREGS-1, next state is RUN; ready rises the following cycle.
  - Sweep takes NREGS cycles after rst deasserts.
  - Writes and pend_set are ignored.
  - rd1, rd2, a0, rs*_pending are forced to 0.
- RUN write: if wr_active, register[wr_addr] <= wv at the clock edge.
- RUN bypass (combinational, zero latency):
  - rd1 = wv when wr_active & wr_addr == rs1_addr; else register[rs1_addr]. rd2 likewise.
  - a0 is bypassed the same way.
- Register 0: reads always return 0; writes to it are discarded; it is never pending.
- Pending scoreboard, one bit per register, updated at the edge in RUN:
  - A write with any valid mode to addr clears bit[addr].
  - pend_set sets bit[pend_addr] (ignored when pend_addr = 0).
  - Set and clear on the same addr in the same cycle: set wins (a new load supersedes the older writeback).
- rs*_pending is combinational:
  - It shows the registered bit, except it reads 0 when a same-cycle write to that addr is active and no same-cycle set targets it.
  - This matches the bypassed data.
- Reset values: ready 0; rd1, rd2, a0, rs1_pending, rs2_pending all 0; pending bits 0; register contents 0 once the sweep completes.

Test Plan:
- Reset sweep: pulse rst 1 cycle with defaults.
  - ready stays 0 for 32 cycles, then goes 1.
  - All 32 registers then read 0.
  - A word write of 0xDEAD_BEEF to x5 attempted during the sweep is not retained.
- Reset mid-sweep: assert rst at sweep cycle 10. The counter restarts; ready rises 32 cycles after the second deassert.
- Extension modes: write wr_data = 0x1234_F08A to x3 with each mode. Next-cycle rd1 (rs1 = x3) reads:
  - 001 → 0x1234_F08A
  - 010 → 0xFFFF_F08A
  - 011 → 0xFFFF_FF8A
  - 110 → 0x0000_F08A
  - 111 → 0x0000_008A
- Bypass and x0:
  - rs1 = rs2 = x7 with a same-cycle word write of 0x55 to x7: rd1 = rd2 = 0x55 in that cycle.
  - Word write of 0x99 to x0: rd1 (rs1 = x0) stays 0.
  - a0 tracks a same-cycle write of 0x42 to x10.
- Scoreboard:
  - pend_set x9, then rs1 = x9: rs1_pending = 1.
  - A later write to x9 drives rs1_pending to 0 in the write cycle and stays 0 after.
  - Simultaneous pend_set x9 and write x9: the bit remains 1.
  - pend_set x0: no effect.
- Invalid mode: wr_mode = 100 with a write to x4 leaves x4 and its pending bit unchanged, and no bypass occurs.
